// File: rtl/int_seq_ctrl_pkg.sv
// Shared types and defaults for the interrupt entry/return sequencer.
// Holds the sequencer state encoding and the default handler vector.
package int_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } state_t;

  localparam logic [31:0] HANDLER_VEC_DEF = 32'h0000_000C;

endpackage

// File: rtl/int_seq_ctrl_sat_down_counter.sv
// Loadable down-counter that saturates at zero; used for the post-ERET holdoff window.
// It keeps counting whether or not the pipeline is stalled.
module sat_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/int_seq_ctrl.sv
// Interrupt entry/return sequencer for the 5-stage MIPS pipeline: latches requests,
// redirects the PC to the handler and back on ERET, and flushes wrong-path stages.
module int_seq_ctrl
  import int_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_VEC = HANDLER_VEC_DEF,
  parameter int          HOLDOFF     = 4,
  parameter int          CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        ie_wen,
  input  logic        ie_din,
  input  logic        stall_in,
  input  logic        eret_id,
  input  logic [31:0] return_addr,
  output logic        epc_ctrl,
  output logic [31:0] epc,
  output logic        flush_id,
  output logic        flush_exe,
  output logic        int_ack,
  output logic        in_handler,
  output logic        ie,
  output logic        int_pending
);

  localparam logic [CNT_W-1:0] HOLDOFF_LD = CNT_W'(HOLDOFF);

  if (HOLDOFF >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("int_seq_ctrl: CNT_W too narrow for HOLDOFF");
  end

  state_t      state, state_next;
  logic [31:0] epc_reg;
  logic        ie_q;
  logic        pending_q;
  logic        holdoff_zero;
  logic        take;

  // Take only from IDLE; ie_q here is the pre-write value even if ie_wen is active.
  assign take = (state == IDLE) & pending_q & ie_q & ~stall_in & holdoff_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
      epc_reg   <= '0;
    end else begin
      state <= state_next;
      if (ie_wen) ie_q <= ie_din;
      // A request arriving in the ack cycle wins over the clear.
      if (int_req)             pending_q <= 1'b1;
      else if (state == ENTER) pending_q <= 1'b0;
      if (take) epc_reg <= return_addr;
    end
  end

  // NOTE: every signal driven in always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (take) state_next = ENTER;
      ENTER:   state_next = HANDLER;
      HANDLER: if (eret_id && !stall_in) state_next = RETURN;
      RETURN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    epc_ctrl   = 1'b0;
    epc        = HANDLER_VEC;
    flush_id   = 1'b0;
    flush_exe  = 1'b0;
    int_ack    = 1'b0;
    in_handler = 1'b0;
    unique case (state)
      ENTER: begin
        epc_ctrl  = 1'b1;
        flush_id  = 1'b1;
        flush_exe = 1'b1;
        int_ack   = 1'b1;
      end
      HANDLER: in_handler = 1'b1;
      RETURN: begin
        epc_ctrl   = 1'b1;
        epc        = epc_reg;
        flush_id   = 1'b1;
        flush_exe  = 1'b1;
        in_handler = 1'b1;
      end
      default: ;
    endcase
  end

  assign ie          = ie_q;
  assign int_pending = pending_q;

  sat_down_counter #(
    .W (CNT_W)
  ) u_holdoff (
    .clk   (clk),
    .rst   (rst),
    .load  (state == RETURN),
    .value (HOLDOFF_LD),
    .zero  (holdoff_zero)
  );

endmodule

// File: tb/tb_int_seq_ctrl.sv
// Directed testbench for int_seq_ctrl: entry, stall gating, ERET/holdoff, masking,
// no-nesting priority and mid-operation reset, with hand-computed expectations.
module tb_int_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req, ie_wen, ie_din, stall_in, eret_id;
  logic [31:0] return_addr;
  logic        epc_ctrl, flush_id, flush_exe, int_ack, in_handler, ie, int_pending;
  logic [31:0] epc;

  int n_cmp = 0;
  int n_bad = 0;

  // Flag bundle: {epc_ctrl, flush_id, flush_exe, int_ack, in_handler, ie, int_pending}
  logic [6:0] flags;
  assign flags = {epc_ctrl, flush_id, flush_exe, int_ack, in_handler, ie, int_pending};

  localparam logic [31:0] VEC = 32'h0000_000C;

  always #5 clk = ~clk;

  int_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .int_req     (int_req),
    .ie_wen      (ie_wen),
    .ie_din      (ie_din),
    .stall_in    (stall_in),
    .eret_id     (eret_id),
    .return_addr (return_addr),
    .epc_ctrl    (epc_ctrl),
    .epc         (epc),
    .flush_id    (flush_id),
    .flush_exe   (flush_exe),
    .int_ack     (int_ack),
    .in_handler  (in_handler),
    .ie          (ie),
    .int_pending (int_pending)
  );

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; int_req = 0; ie_wen = 0; ie_din = 0; stall_in = 0; eret_id = 0;
    return_addr = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic set_ie();
    ie_wen = 1'b1; ie_din = 1'b1;
    step();
    ie_wen = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (flags !== 7'b0000000) begin
      $display("FAIL reset_flags: got %b want %b", flags, 7'b0000000); n_bad++;
    end
    n_cmp++;
    if (epc !== VEC) begin
      $display("FAIL reset_epc: got %h want %h", epc, VEC); n_bad++;
    end
  endtask

  task automatic test_basic_entry();
    return_addr = 32'h0000_0040;
    set_ie();
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    n_cmp++;
    if (flags !== 7'b0000011) begin
      $display("FAIL basic_pending: got %b want %b", flags, 7'b0000011); n_bad++;
    end
    step();
    n_cmp++;
    if (flags !== 7'b1111011 || epc !== VEC) begin
      $display("FAIL basic_enter: got %b/%h want %b/%h", flags, epc, 7'b1111011, VEC); n_bad++;
    end
    step();
    n_cmp++;
    if (flags !== 7'b0000110) begin
      $display("FAIL basic_handler: got %b want %b", flags, 7'b0000110); n_bad++;
    end
    step();
    n_cmp++;
    if (flags !== 7'b0000110) begin
      $display("FAIL basic_handler_hold: got %b want %b", flags, 7'b0000110); n_bad++;
    end
  endtask

  // Enters from HANDLER with epc_reg = 0x40 and int_req held high throughout.
  task automatic test_eret_holdoff();
    int_req = 1'b1; eret_id = 1'b1;
    step();
    eret_id = 1'b0;
    n_cmp++;
    if (flags !== 7'b1110111 || epc !== 32'h0000_0040) begin
      $display("FAIL eret_return: got %b/%h want %b/%h", flags, epc, 7'b1110111, 32'h40); n_bad++;
    end
    // Holdoff loads 4: IDLE cycles with count 4,3,2,1,0; take on the last one.
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (flags !== 7'b0000011 || epc !== VEC) begin
        $display("FAIL eret_holdoff[%0d]: got %b/%h want %b/%h", i, flags, epc, 7'b0000011, VEC);
        n_bad++;
      end
    end
    int_req = 1'b0;
    step();
    n_cmp++;
    if (flags !== 7'b1111011) begin
      $display("FAIL eret_reenter: got %b want %b", flags, 7'b1111011); n_bad++;
    end
    step();
    n_cmp++;
    if (flags !== 7'b0000110) begin
      $display("FAIL eret_handler: got %b want %b", flags, 7'b0000110); n_bad++;
    end
  endtask

  // Enters from HANDLER: a request arrives, then ERET and a request coincide.
  task automatic test_no_nesting();
    int_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (flags !== 7'b0000111) begin
        $display("FAIL nest_hold[%0d]: got %b want %b", i, flags, 7'b0000111); n_bad++;
      end
    end
    eret_id = 1'b1;
    step();
    eret_id = 1'b0; int_req = 1'b0;
    n_cmp++;
    if (flags !== 7'b1110111) begin
      $display("FAIL nest_return: got %b want %b", flags, 7'b1110111); n_bad++;
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (flags !== 7'b0000011) begin
        $display("FAIL nest_holdoff[%0d]: got %b want %b", i, flags, 7'b0000011); n_bad++;
      end
    end
    step();
    n_cmp++;
    if (flags !== 7'b1111011) begin
      $display("FAIL nest_reenter: got %b want %b", flags, 7'b1111011); n_bad++;
    end
    step();
  endtask

  task automatic test_stall_gating();
    do_reset();
    set_ie();
    return_addr = 32'h0000_0100;
    int_req = 1'b1; stall_in = 1'b1;
    step();
    int_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      return_addr = 32'h0000_0200 + 32'(i);
      step();
      n_cmp++;
      if (flags !== 7'b0000011) begin
        $display("FAIL stall_hold[%0d]: got %b want %b", i, flags, 7'b0000011); n_bad++;
      end
    end
    stall_in = 1'b0; return_addr = 32'h0000_0300;
    step();
    return_addr = 32'h0000_0400;
    n_cmp++;
    if (flags !== 7'b1111011) begin
      $display("FAIL stall_enter: got %b want %b", flags, 7'b1111011); n_bad++;
    end
    step();
    // ERET with stall waits in HANDLER; then returns to the release-cycle PC.
    eret_id = 1'b1; stall_in = 1'b1;
    step();
    n_cmp++;
    if (flags !== 7'b0000110) begin
      $display("FAIL stall_eret_wait: got %b want %b", flags, 7'b0000110); n_bad++;
    end
    stall_in = 1'b0;
    step();
    eret_id = 1'b0;
    n_cmp++;
    if (flags !== 7'b1110110 || epc !== 32'h0000_0300) begin
      $display("FAIL stall_epc: got %b/%h want %b/%h", flags, epc, 7'b1110110, 32'h300); n_bad++;
    end
    step();
  endtask

  task automatic test_masking();
    do_reset();
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (flags !== 7'b0000001) begin
        $display("FAIL mask_hold[%0d]: got %b want %b", i, flags, 7'b0000001); n_bad++;
      end
    end
    ie_wen = 1'b1; ie_din = 1'b1;
    step();
    ie_wen = 1'b0;
    n_cmp++;
    if (flags !== 7'b0000011) begin
      $display("FAIL mask_write: got %b want %b", flags, 7'b0000011); n_bad++;
    end
    step();
    n_cmp++;
    if (flags !== 7'b1111011) begin
      $display("FAIL mask_enter: got %b want %b", flags, 7'b1111011); n_bad++;
    end
  endtask

  // Enters while the DUT sits in ENTER (left there by test_masking).
  task automatic test_reset_mid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (flags !== 7'b0000000 || epc !== VEC) begin
      $display("FAIL rst_enter: got %b/%h want %b/%h", flags, epc, 7'b0000000, VEC); n_bad++;
    end
    set_ie();
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    step(); step();
    n_cmp++;
    if (flags !== 7'b0000110) begin
      $display("FAIL rst_reach_handler: got %b want %b", flags, 7'b0000110); n_bad++;
    end
    int_req = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; int_req = 1'b0;
    n_cmp++;
    if (flags !== 7'b0000000 || epc !== VEC) begin
      $display("FAIL rst_handler: got %b/%h want %b/%h", flags, epc, 7'b0000000, VEC); n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_eret_holdoff();
    test_no_nesting();
    test_stall_gating();
    test_masking();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
